// File: rtl/control_pkg.sv
// Shared control-word layout, phase/class/fault encodings and helpers for the
// LEGv8 multi-cycle control sequencer.
package control_pkg;

  localparam int CW_WIDTH = 33;

  localparam int ALU_EN_BIT     = 32;
  localparam int ALU_BS_BIT     = 31;
  localparam int ALU_FS_LSB     = 26;
  localparam int RF_B_EN_BIT    = 25;
  localparam int RF_SA_LSB      = 20;
  localparam int RF_SB_LSB      = 15;
  localparam int RF_DA_LSB      = 10;
  localparam int RF_W_BIT       = 9;
  localparam int RAM_EN_BIT     = 8;
  localparam int RAM_W_BIT      = 7;
  localparam int PC_EN_BIT      = 6;
  localparam int PC_FS_LSB      = 4;
  localparam int PC_IS_BIT      = 3;
  localparam int STATUS_LD_BIT  = 2;
  localparam int NEXT_STATE_LSB = 0;

  localparam logic [CW_WIDTH-1:0] SAFE_CW = '0;

  typedef enum logic [1:0] {
    PH_FETCH = 2'd0,
    PH_EXEC  = 2'd1,
    PH_HALT  = 2'd2
  } phase_e;

  typedef enum logic [3:0] {
    CLS_R_ARITH = 4'd0,
    CLS_I_ARITH = 4'd1,
    CLS_LOG_IMM = 4'd2,
    CLS_MOVZ    = 4'd3,
    CLS_MOVK    = 4'd4,
    CLS_LDST    = 4'd5,
    CLS_BRANCH  = 4'd6,
    CLS_CBZ     = 4'd7,
    CLS_ILLEGAL = 4'd8
  } opclass_e;

  typedef enum logic [1:0] {
    FAULT_NONE    = 2'b00,
    FAULT_ILLEGAL = 2'b01,
    FAULT_LIMIT   = 2'b10
  } fault_e;

  // While the data RAM is busy, suppress every side effect that would commit
  // a result; addresses and selects still pass so the access stays stable.
  function automatic logic [CW_WIDTH-1:0] stall_cw(input logic [CW_WIDTH-1:0] cw);
    logic [CW_WIDTH-1:0] masked;
    masked                    = cw;
    masked[RF_W_BIT]          = 1'b0;
    masked[RAM_W_BIT]         = 1'b0;
    masked[STATUS_LD_BIT]     = 1'b0;
    masked[PC_FS_LSB +: 2]    = 2'b00;
    return masked;
  endfunction

endpackage

// File: rtl/opcode_classifier.sv
// Combinational LEGv8 opcode decoder: instr[31:21] -> decoder slot index,
// with a separate flag for encodings no decoder handles.
module opcode_classifier
  import control_pkg::*;
(
  input  logic [10:0] opcode_i,
  output logic [2:0]  class_o,
  output logic        illegal_o
);

  opclass_e cls;

  // Field widths differ per format (R: 11, I: 10, IW: 9, CB: 8, B: 6 bits).
  always_comb begin
    cls = CLS_ILLEGAL;
    casez (opcode_i)
      11'b10001011000, 11'b10101011000,
      11'b11001011000, 11'b11101011000: cls = CLS_R_ARITH;
      11'b1001000100?, 11'b1011000100?,
      11'b1101000100?, 11'b1111000100?: cls = CLS_I_ARITH;
      11'b1001001000?, 11'b1011001000?,
      11'b1101001000?, 11'b1111001000?: cls = CLS_LOG_IMM;
      11'b110100101??:                  cls = CLS_MOVZ;
      11'b111100101??:                  cls = CLS_MOVK;
      11'b11111000010, 11'b11111000000: cls = CLS_LDST;
      11'b000101?????, 11'b100101?????: cls = CLS_BRANCH;
      11'b1011010????:                  cls = CLS_CBZ;
      default:                          cls = CLS_ILLEGAL;
    endcase
  end

  assign class_o   = cls[2:0];
  assign illegal_o = (cls == CLS_ILLEGAL);

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle LEGv8 control sequencer: fetches into the instruction register,
// steps the execution sub-state and muxes the active decoder's control word.
module control_sequencer
  import control_pkg::*;
#(
  parameter int NUM_CLASSES = 8,
  parameter int EXEC_LIMIT  = 4
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [31:0]                     imem_data,
  input  logic                            imem_valid,
  output logic                            imem_req,
  input  logic                            mem_ready,
  input  logic [4:0]                      status_in,
  input  logic [NUM_CLASSES*CW_WIDTH-1:0] cw_all,
  output logic [31:0]                     instr,
  output logic [1:0]                      state,
  output logic [4:0]                      flags,
  output logic [2:0]                      class_sel,
  output logic [CW_WIDTH-1:0]             cw_out,
  output logic                            halted,
  output logic [1:0]                      fault
);

  localparam int CNT_W = $clog2(EXEC_LIMIT + 1);

  phase_e             phase_q, phase_d;
  logic [31:0]        instr_q, instr_d;
  logic [1:0]         state_q, state_d;
  logic [4:0]         flags_q, flags_d;
  fault_e             fault_q, fault_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               illegal;
  logic [CW_WIDTH-1:0] slot_w [NUM_CLASSES];
  logic [CW_WIDTH-1:0] slot_cw;
  logic [CNT_W-1:0]   cnt_inc;

  opcode_classifier u_classifier (
    .opcode_i  (instr_q[31:21]),
    .class_o   (class_sel),
    .illegal_o (illegal)
  );

  for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_slot
    assign slot_w[k] = cw_all[k*CW_WIDTH +: CW_WIDTH];
  end

  assign slot_cw = slot_w[class_sel];
  assign cnt_inc = cnt_q + CNT_W'(1);

  // NOTE: every signal written here gets its default first, so no path through
  // the case/if tree can leave one unassigned and infer a latch.
  always_comb begin
    phase_d = phase_q;
    instr_d = instr_q;
    state_d = state_q;
    flags_d = flags_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    cw_out  = SAFE_CW;

    case (phase_q)
      PH_FETCH: begin
        if (imem_valid) begin
          instr_d = imem_data;
          state_d = 2'b00;
          cnt_d   = '0;
          phase_d = PH_EXEC;
        end
      end
      PH_EXEC: begin
        if (illegal) begin
          phase_d = PH_HALT;
          fault_d = FAULT_ILLEGAL;
        end else if (slot_cw[RAM_EN_BIT] && !mem_ready) begin
          // Stalled: nothing commits, state and counter hold.
          cw_out = stall_cw(slot_cw);
        end else begin
          cw_out = slot_cw;
          if (slot_cw[STATUS_LD_BIT]) flags_d = status_in;
          cnt_d   = cnt_inc;
          state_d = slot_cw[NEXT_STATE_LSB +: 2];
          if (slot_cw[NEXT_STATE_LSB +: 2] == 2'b00) begin
            phase_d = PH_FETCH;
          end else if (cnt_inc == CNT_W'(EXEC_LIMIT)) begin
            state_d = state_q;
            phase_d = PH_HALT;
            fault_d = FAULT_LIMIT;
          end
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase_q <= PH_FETCH;
      instr_q <= '0;
      state_q <= 2'b00;
      flags_q <= '0;
      fault_q <= FAULT_NONE;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      instr_q <= instr_d;
      state_q <= state_d;
      flags_q <= flags_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_req = (phase_q == PH_FETCH);
  assign halted   = (phase_q == PH_HALT);
  assign instr    = instr_q;
  assign state    = state_q;
  assign flags    = flags_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed scenarios plus a
// randomized run scored against an instruction-level reference model.
module tb_control_sequencer;

  localparam int CW    = 33;
  localparam int NCLS  = 8;
  localparam int LIMIT = 4;
  localparam int P_FETCH = 0, P_EXEC = 1, P_HALT = 2;

  localparam logic [31:0] MOVK_X3 = {9'b111100101, 2'b01, 16'hBEEF, 5'd3};
  localparam logic [31:0] LDUR_X1 = {11'b11111000010, 9'd8, 2'b00, 5'd2, 5'd1};
  localparam logic [31:0] ADD_X0  = {11'b10001011000, 5'd2, 6'd0, 5'd1, 5'd0};

  logic              clock = 1'b0;
  logic              reset;
  logic [31:0]       imem_data;
  logic              imem_valid;
  logic              imem_req;
  logic              mem_ready;
  logic [4:0]        status_in;
  logic [NCLS*CW-1:0] cw_all;
  logic [31:0]       instr;
  logic [1:0]        state;
  logic [4:0]        flags;
  logic [2:0]        class_sel;
  logic [CW-1:0]     cw_out;
  logic              halted;
  logic [1:0]        fault;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  control_sequencer dut (
    .clock      (clock),
    .reset      (reset),
    .imem_data  (imem_data),
    .imem_valid (imem_valid),
    .imem_req   (imem_req),
    .mem_ready  (mem_ready),
    .status_in  (status_in),
    .cw_all     (cw_all),
    .instr      (instr),
    .state      (state),
    .flags      (flags),
    .class_sel  (class_sel),
    .cw_out     (cw_out),
    .halted     (halted),
    .fault      (fault)
  );

  // Control word with the fields that matter set explicitly, the rest random.
  function automatic logic [CW-1:0] mk_cw(input logic ram_en, input logic rf_w,
                                          input logic status_ld, input logic [1:0] pc_fs,
                                          input logic [1:0] ns);
    logic [CW-1:0] w;
    w      = {1'b1, 32'($urandom)};
    w[8]   = ram_en;
    w[9]   = rf_w;
    w[2]   = status_ld;
    w[5:4] = pc_fs;
    w[1:0] = ns;
    return w;
  endfunction

  function automatic logic [CW-1:0] rand_cw();
    logic [1:0] ns;
    ns = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
    return mk_cw(($urandom_range(0, 2) == 0), 1'($urandom), 1'($urandom),
                 2'($urandom), ns);
  endfunction

  // LEGv8 opcode table by mnemonic; -1 means no decoder owns the encoding.
  function automatic int ref_class(input logic [31:0] w);
    logic [10:0] op;
    op = w[31:21];
    if (op inside {11'b10001011000, 11'b10101011000, 11'b11001011000, 11'b11101011000})
      return 0;                                       // ADD ADDS SUB SUBS
    if (op[10:1] inside {10'b1001000100, 10'b1011000100, 10'b1101000100, 10'b1111000100})
      return 1;                                       // ADDI ADDIS SUBI SUBIS
    if (op[10:1] inside {10'b1001001000, 10'b1011001000, 10'b1101001000, 10'b1111001000})
      return 2;                                       // ANDI ORRI EORI ANDIS
    if (op[10:2] == 9'b110100101) return 3;           // MOVZ
    if (op[10:2] == 9'b111100101) return 4;           // MOVK
    if (op inside {11'b11111000010, 11'b11111000000}) return 5;  // LDUR STUR
    if (op[10:5] inside {6'b000101, 6'b100101}) return 6;        // B BL
    if (op[10:3] inside {8'b10110100, 8'b10110101}) return 7;    // CBZ CBNZ
    return -1;
  endfunction

  function automatic logic [31:0] rand_instr();
    case ($urandom_range(0, 9))
      0: return {11'b11101011000, 21'($urandom)};
      1: return {10'b1011000100, 22'($urandom)};
      2: return {10'b1101001000, 22'($urandom)};
      3: return {9'b110100101, 23'($urandom)};
      4: return {9'b111100101, 23'($urandom)};
      5: return {11'b11111000000, 21'($urandom)};
      6: return {6'b100101, 26'($urandom)};
      7: return {8'b10110101, 24'($urandom)};
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic set_slot(input int k, input logic [CW-1:0] v);
    cw_all[k*CW +: CW] = v;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    imem_valid = 1'b0;
    imem_data  = '0;
    mem_ready  = 1'b1;
    status_in  = '0;
    cw_all     = '0;
    reset      = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    set_slot(0, mk_cw(0, 1, 1, 2'b01, 2'b01));
    #1;
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 00000000", instr); end
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state: got %b want 00", state); end
    checks++; if (flags !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b want 00000", flags); end
    checks++; if (halted !== 1'b0 || fault !== 2'b00) begin errors++; $display("FAIL reset_halt_fault: got %b/%b want 0/00", halted, fault); end
    checks++; if (imem_req !== 1'b1 || cw_out !== '0) begin errors++; $display("FAIL reset_fetch_out: got req=%b cw=%h want 1/0", imem_req, cw_out); end
  endtask

  task automatic test_movk();
    logic [CW-1:0] cw_a, cw_b;
    cw_a = mk_cw(0, 1, 0, 2'b00, 2'b01);
    cw_b = mk_cw(0, 0, 0, 2'b01, 2'b00);
    cw_b[6] = 1'b1;
    set_slot(4, cw_a);
    imem_data = MOVK_X3; imem_valid = 1'b1;
    tick();
    imem_valid = 1'b0;
    checks++; if (imem_req !== 1'b0 || class_sel !== 3'd4) begin errors++; $display("FAIL movk_exec: got req=%b cls=%0d want 0/4", imem_req, class_sel); end
    checks++; if (state !== 2'b00 || instr !== MOVK_X3) begin errors++; $display("FAIL movk_ir: got st=%b ir=%h want 00/%h", state, instr, MOVK_X3); end
    checks++; if (cw_out !== cw_a) begin errors++; $display("FAIL movk_cw0: got %h want %h", cw_out, cw_a); end
    tick();
    checks++; if (state !== 2'b01 || imem_req !== 1'b0) begin errors++; $display("FAIL movk_state1: got st=%b req=%b want 01/0", state, imem_req); end
    set_slot(4, cw_b);
    #1;
    checks++; if (cw_out !== cw_b) begin errors++; $display("FAIL movk_cw1: got %h want %h", cw_out, cw_b); end
    tick();
    checks++; if (imem_req !== 1'b1 || halted !== 1'b0) begin errors++; $display("FAIL movk_refetch: got req=%b halted=%b want 1/0", imem_req, halted); end
  endtask

  task automatic test_fetch_wait();
    cw_all = {9{32'hFFFF_FFFF}};
    imem_data = ADD_X0; imem_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (imem_req !== 1'b1 || cw_out !== '0 || instr !== MOVK_X3) begin
        errors++;
        $display("FAIL fetch_wait[%0d]: got req=%b cw=%h ir=%h want 1/0/%h", i, imem_req, cw_out, instr, MOVK_X3);
      end
    end
  endtask

  task automatic test_illegal();
    imem_data = 32'h0; imem_valid = 1'b1;
    tick();
    imem_valid = 1'b0;
    checks++; if (imem_req !== 1'b0 || cw_out !== '0 || halted !== 1'b0) begin errors++; $display("FAIL illegal_exec: got req=%b cw=%h halted=%b want 0/0/0", imem_req, cw_out, halted); end
    tick();
    checks++; if (halted !== 1'b1 || fault !== 2'b01) begin errors++; $display("FAIL illegal_halt: got halted=%b fault=%b want 1/01", halted, fault); end
    imem_data = ADD_X0; imem_valid = 1'b1;
    repeat (3) tick();
    checks++; if (halted !== 1'b1 || instr !== 32'h0 || imem_req !== 1'b0 || cw_out !== '0) begin errors++; $display("FAIL illegal_sticky: got halted=%b ir=%h req=%b cw=%h want 1/0/0/0", halted, instr, imem_req, cw_out); end
    do_reset();
  endtask

  task automatic test_stall();
    logic [CW-1:0] full, held;
    full = mk_cw(1, 1, 1, 2'b10, 2'b01);
    held = full;
    held[9] = 1'b0; held[7] = 1'b0; held[2] = 1'b0; held[5:4] = 2'b00;
    set_slot(5, full);
    imem_data = LDUR_X1; imem_valid = 1'b1; mem_ready = 1'b0; status_in = 5'b10110;
    tick();
    imem_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++; if (cw_out !== held) begin errors++; $display("FAIL stall_cw[%0d]: got %h want %h", i, cw_out, held); end
      tick();
      checks++; if (state !== 2'b00 || flags !== 5'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL stall_hold[%0d]: got st=%b fl=%b req=%b want 00/00000/0", i, state, flags, imem_req); end
    end
    mem_ready = 1'b1;
    #1;
    checks++; if (cw_out !== full) begin errors++; $display("FAIL stall_release_cw: got %h want %h", cw_out, full); end
    tick();
    checks++; if (state !== 2'b01 || flags !== 5'b10110) begin errors++; $display("FAIL stall_advance: got st=%b fl=%b want 01/10110", state, flags); end
    set_slot(5, mk_cw(0, 0, 0, 2'b00, 2'b00));
    tick();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL stall_done: got req=%b want 1", imem_req); end
  endtask

  task automatic test_flags();
    set_slot(0, mk_cw(0, 0, 1, 2'b00, 2'b00));
    imem_data = ADD_X0; imem_valid = 1'b1; status_in = 5'b01001;
    tick();
    imem_valid = 1'b0;
    checks++; if (flags !== 5'b10110) begin errors++; $display("FAIL flags_before: got %b want 10110", flags); end
    tick();
    checks++; if (flags !== 5'b01001 || imem_req !== 1'b1) begin errors++; $display("FAIL flags_load: got fl=%b req=%b want 01001/1", flags, imem_req); end
  endtask

  task automatic test_limit();
    set_slot(0, mk_cw(0, 1, 0, 2'b00, 2'b01));
    imem_data = ADD_X0; imem_valid = 1'b1;
    tick();
    imem_valid = 1'b0;
    for (int i = 1; i < LIMIT; i++) begin
      tick();
      checks++; if (halted !== 1'b0 || state !== 2'b01 || imem_req !== 1'b0) begin errors++; $display("FAIL limit_run[%0d]: got halted=%b st=%b req=%b want 0/01/0", i, halted, state, imem_req); end
    end
    tick();
    checks++; if (halted !== 1'b1 || fault !== 2'b10 || cw_out !== '0 || imem_req !== 1'b0) begin errors++; $display("FAIL limit_halt: got halted=%b fault=%b cw=%h req=%b want 1/10/0/0", halted, fault, cw_out, imem_req); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_slot(4, mk_cw(0, 1, 1, 2'b00, 2'b01));
    imem_data = MOVK_X3; imem_valid = 1'b1; status_in = 5'b11111;
    tick();
    imem_valid = 1'b0;
    tick();
    checks++; if (state !== 2'b01 || flags !== 5'b11111) begin errors++; $display("FAIL midrst_pre: got st=%b fl=%b want 01/11111", state, flags); end
    #3 reset = 1'b1;
    #1;
    checks++; if (instr !== 32'h0 || state !== 2'b00 || flags !== 5'b0) begin errors++; $display("FAIL midrst_regs: got ir=%h st=%b fl=%b want 0/00/00000", instr, state, flags); end
    checks++; if (cw_out !== '0 || imem_req !== 1'b1 || halted !== 1'b0 || fault !== 2'b00) begin errors++; $display("FAIL midrst_outs: got cw=%h req=%b halted=%b fault=%b want 0/1/0/00", cw_out, imem_req, halted, fault); end
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic test_random();
    int            m_phase, m_count, cls;
    logic [31:0]   m_instr;
    logic [1:0]    m_state, m_fault;
    logic [4:0]    m_flags;
    logic [CW-1:0] slot, exp_cw;
    do_reset();
    m_phase = P_FETCH; m_instr = '0; m_state = '0; m_flags = '0; m_fault = '0; m_count = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clock);
      if (m_phase == P_HALT && $urandom_range(0, 2) == 0) begin
        reset = 1'b1;
        #1 reset = 1'b0;
        m_phase = P_FETCH; m_instr = '0; m_state = '0; m_flags = '0; m_fault = '0; m_count = 0;
      end
      imem_valid = ($urandom_range(0, 3) != 0);
      imem_data  = rand_instr();
      mem_ready  = ($urandom_range(0, 2) != 0);
      status_in  = 5'($urandom);
      for (int k = 0; k < NCLS; k++) set_slot(k, rand_cw());
      #1;
      cls    = ref_class(m_instr);
      exp_cw = '0;
      if (m_phase == P_EXEC && cls >= 0) begin
        slot   = cw_all[cls*CW +: CW];
        exp_cw = slot;
        if (slot[8] && !mem_ready) begin
          exp_cw[9] = 1'b0; exp_cw[7] = 1'b0; exp_cw[2] = 1'b0; exp_cw[5:4] = 2'b00;
        end
      end
      checks++; if (cw_out !== exp_cw) begin errors++; $display("FAIL rnd_cw @%0d: got %h want %h", cyc, cw_out, exp_cw); end
      checks++; if (imem_req !== (m_phase == P_FETCH) || halted !== (m_phase == P_HALT)) begin errors++; $display("FAIL rnd_phase @%0d: got req=%b halted=%b want phase %0d", cyc, imem_req, halted, m_phase); end
      if (cls >= 0) begin
        checks++; if (class_sel !== 3'(cls)) begin errors++; $display("FAIL rnd_class @%0d: got %0d want %0d", cyc, class_sel, cls); end
      end
      @(posedge clock);
      case (m_phase)
        P_FETCH: if (imem_valid) begin
          m_instr = imem_data; m_state = 2'b00; m_count = 0; m_phase = P_EXEC;
        end
        P_EXEC: begin
          if (cls < 0) begin
            m_phase = P_HALT; m_fault = 2'b01;
          end else if (!(slot[8] && !mem_ready)) begin
            if (slot[2]) m_flags = status_in;
            m_count++;
            if (slot[1:0] == 2'b00) m_phase = P_FETCH;
            else if (m_count == LIMIT) begin m_phase = P_HALT; m_fault = 2'b10; end
            else m_state = slot[1:0];
          end
        end
        default: ;
      endcase
      #1;
      checks++; if (instr !== m_instr || flags !== m_flags || fault !== m_fault) begin errors++; $display("FAIL rnd_regs @%0d: got ir=%h fl=%b ft=%b want %h/%b/%b", cyc, instr, flags, fault, m_instr, m_flags, m_fault); end
      if (m_phase == P_EXEC) begin
        checks++; if (state !== m_state) begin errors++; $display("FAIL rnd_state @%0d: got %b want %b", cyc, state, m_state); end
      end
    end
  endtask

  initial begin
    reset = 1'b1; imem_valid = 1'b0; imem_data = '0; mem_ready = 1'b1;
    status_in = '0; cw_all = '0;
    test_reset();
    test_movk();
    test_fetch_wait();
    test_illegal();
    test_stall();
    test_flags();
    test_limit();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Multi-cycle control-unit sequencer for the LEGv8 core. Fetches an instruction word into the instruction register and classifies its opcode. It steps the 2-bit execution sub-state through the per-instruction decoders (MOVK, MOVZ, arithmetic, load/store, branch, …) and drives the selected 33-bit control word onto the datapath. It sits directly downstream of the per-instruction decoders, which consume `instr`, `state` and `flags`, and upstream of the datapath.

## Interface
- `NUM_CLASSES`, 8: number of decoder control-word slots on `cw_all`.
- `CW_WIDTH`, 33: control-word width.
- `EXEC_LIMIT`, 4: maximum consecutive execute cycles per instruction before a fault.

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `imem_data`  in  32  instruction word from instruction memory.
- `imem_valid`  in  1  `imem_data` is valid this cycle.
- `imem_req`  out  1  fetch request.
- `mem_ready`  in  1  data RAM has completed the current access.
- `status_in`  in  5  ALU status flags.
- `cw_all`  in  `NUM_CLASSES*CW_WIDTH`  packed decoder control words; slot k is bits [k*33+32 : k*33].
- `instr`  out  32  instruction register, broadcast to the decoders.
- `state`  out  2  execution sub-state, broadcast to the decoders.
- `flags`  out  5  latched status register.
- `class_sel`  out  3  opcode class of `instr`.
- `cw_out`  out  33  control word to the datapath.
- `halted`  out  1  sequencer stopped.
- `fault`  out  2  fault code: 00 none, 01 illegal opcode, 10 exec-limit overrun.

## Operation
- Control-word fields, MSB to LSB:
  - alu_en[32], alu_bs[31], alu_fs[30:26], rf_b_en[25]
  - rf_sa[24:20], rf_sb[19:15], rf_da[14:10], rf_w[9]
  - ram_en[8], ram_w[7], pc_en[6], pc_fs[5:4], pc_is[3]
  - status_ld[2], next_state[1:0]
- Phases: FETCH, EXEC, HALT. Reset enters FETCH.
- Reset values: `instr`=0, `state`=00, `flags`=0, `halted`=0, `fault`=00, exec counter=0.
- FETCH:
  - `imem_req`=1 and `cw_out`=`SAFE_CW`: all enables/writes 0, pc_fs=00, next_state=00.
  - On `imem_valid`: `instr`<=`imem_data`, `state`<=00, counter<=0, go to EXEC.
  - Without `imem_valid`: stay in FETCH indefinitely.
- EXEC, illegal opcode:
  - If `class_sel` = ILLEGAL, `cw_out`=`SAFE_CW`.
  - Next edge: go to HALT with `fault`=01.
- EXEC, legal opcode:
  - `cw_out` = slot `class_sel` of `cw_all`.
- EXEC, RAM stall:
  - If ram_en=1 and `mem_ready`=0, force rf_w, ram_w, status_ld and pc_fs to 0 on `cw_out`.
  - Hold `state` and the counter; the other fields pass unchanged.
- EXEC, advance (not stalled):
  - If status_ld=1: `flags`<=`status_in`.
  - Counter +1.
  - If next_state=00: go to FETCH.
  - Otherwise: `state`<=next_state and stay in EXEC.
- EXEC, limit:
  - If the counter would reach `EXEC_LIMIT` with next_state≠00, go to HALT with `fault`=10.
- HALT: `cw_out`=`SAFE_CW`, `imem_req`=0, `halted`=1. Only `reset` leaves HALT.
- Opcode classes (from `instr[31:21]`, LEGv8 encodings):
  - 0 R-arith, 1 I-arith, 2 logical-imm, 3 MOVZ (9-bit op 110100101), 4 MOVK (111100101), 5 LDUR/STUR, 6 B/BL, 7 CBZ/CBNZ.
  - Every other encoding is ILLEGAL.

## Timing
- Fetch latency: `imem_req` to EXEC is 1 edge after `imem_valid`. A 2-sub-state instruction (e.g. MOVK 00→01→00) takes 3 cycles with zero-wait memory.
- `cw_out`, `imem_req`, `class_sel` are combinational from registered phase/`instr`/`state` and from `cw_all`/`mem_ready`. The path `cw_all`→`cw_out` has no registers.
- `imem_valid` outside FETCH is ignored.
- Stall and status_ld in the same cycle: no flag load until the stall clears.
- `reset` asserted mid-EXEC: all registers clear immediately; no partial write is issued once reset is high.

## Structure
- Package `control_pkg`: `CW_WIDTH`, field bit-position constants, `SAFE_CW`, phase enum (FETCH/EXEC/HALT), class enum including ILLEGAL, fault codes.
- Sub-module `opcode_classifier`: combinational, `instr[31:21]` → 3-bit class plus illegal flag.

## Test plan
- Reset then `imem_data`=MOVK X3,#0xBEEF,LSL#16 with `imem_valid` → next cycle EXEC, `class_sel`=4, `state`=00. Slot 4 next_state=01 → `state`=01. Slot 4 next_state=00, pc_fs=01 → FETCH. 3 cycles total.
- Fetch with `imem_valid` low for 5 cycles → `imem_req` held at 1, `cw_out`=`SAFE_CW`, `instr` unchanged.
- `imem_data`=0x00000000 → one EXEC cycle with `SAFE_CW`, then `halted`=1, `fault`=01. Further `imem_valid` is ignored until reset.
- LDUR slot with ram_en=1, `mem_ready`=0 for 2 cycles → `state` held, rf_w=0 on `cw_out`. `mem_ready`=1 → rf_w passes and the block advances.
- Slot with status_ld=1, `status_in`=5'b10110 → `flags`=5'b10110 next cycle. The same stimulus with the stall active leaves `flags` unchanged.
- A slot always returning next_state=01 → HALT with `fault`=10 after 4 EXEC cycles. Asserting `reset` mid-sequence → all outputs return to reset values asynchronously.
